// File: rtl/pipelined_multiplier.sv
// pipelined_multiplier: shift-add multiplier with one accumulate stage per
// multiplier bit. Operands, mode and tag travel down the pipe with a valid bit;
// a blocked output freezes every stage at once, so nothing is lost or reordered.
module pipelined_multiplier #(
  parameter int unsigned A_WIDTH   = 11,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_a,
  input  logic [B_WIDTH-1:0]         in_b,
  input  logic                       in_a_signed,
  input  logic                       in_b_signed,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] out_product,
  output logic [TAG_WIDTH-1:0]       out_tag
);

  localparam int unsigned P = A_WIDTH + B_WIDTH;

  // Stage 0 .. B_WIDTH control/sideband; operands only needed up to B_WIDTH-1
  logic [B_WIDTH:0]     vld_q;
  logic [TAG_WIDTH-1:0] tag_q [0:B_WIDTH];
  logic [P-1:0]         a_q   [0:B_WIDTH-1];
  logic [B_WIDTH-1:0]   b_q   [0:B_WIDTH-1];
  logic [B_WIDTH-1:0]   bs_q;
  logic [P-1:0]         sum_q [1:B_WIDTH];
  logic [P-1:0]         sum_d [1:B_WIDTH];

  logic         stall;
  logic [P-1:0] a_ext_d;

  // Global stall: the whole pipe freezes when the product cannot leave
  assign stall    = vld_q[B_WIDTH] & ~out_ready;
  assign in_ready = ~stall;

  // Multiplicand widened once at capture; sign fill only in signed mode
  assign a_ext_d = {{B_WIDTH{in_a_signed & in_a[A_WIDTH-1]}}, in_a};

  // Accumulate stages: stage k folds in multiplier bit k-1; the top bit of a
  // signed multiplier carries negative weight, so it is subtracted
  for (genvar k = 1; k <= B_WIDTH; k++) begin : g_acc
    logic [P-1:0] prev;
    logic [P-1:0] pp;

    if (k == 1) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = sum_q[k-1];
    end

    assign pp = b_q[k-1][k-1] ? (a_q[k-1] << (k - 1)) : '0;

    if (k == B_WIDTH) begin : g_last
      assign sum_d[k] = bs_q[k-1] ? (prev - pp) : (prev + pp);
    end else begin : g_mid
      assign sum_d[k] = prev + pp;
    end
  end

  // Pipeline registers: hold on stall, otherwise shift one stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      bs_q  <= '0;
      for (int k = 0; k <= int'(B_WIDTH); k++) begin
        tag_q[k] <= '0;
      end
      for (int k = 0; k < int'(B_WIDTH); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= int'(B_WIDTH); k++) begin
        sum_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q    <= {vld_q[B_WIDTH-1:0], in_valid};
      bs_q     <= {bs_q[B_WIDTH-2:0], in_b_signed};
      a_q[0]   <= a_ext_d;
      b_q[0]   <= in_b;
      tag_q[0] <= in_tag;
      for (int k = 1; k < int'(B_WIDTH); k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= int'(B_WIDTH); k++) begin
        tag_q[k] <= tag_q[k-1];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid   = vld_q[B_WIDTH];
  assign out_product = sum_q[B_WIDTH];
  assign out_tag     = tag_q[B_WIDTH];

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Bench for pipelined_multiplier: directed spec vectors plus randomized traffic
// scored against an arithmetic reference model held in an expected-value queue.
module tb_pipelined_multiplier;

  localparam int unsigned A_W = 11;
  localparam int unsigned B_W = 8;
  localparam int unsigned T_W = 4;
  localparam int unsigned P   = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic           in_a_signed;
  logic           in_b_signed;
  logic [T_W-1:0] in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [P-1:0]   out_product;
  logic [T_W-1:0] out_tag;

  typedef struct {
    logic [P-1:0]   p;
    logic [T_W-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rx_cnt   = 0;

  pipelined_multiplier #(.A_WIDTH(A_W), .B_WIDTH(B_W), .TAG_WIDTH(T_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_a_signed (in_a_signed),
    .in_b_signed (in_b_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product of the interpreted operands, kept mod 2^P
  function automatic logic [P-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                           input logic as, input logic bs);
    longint av;
    longint bv;
    av = as ? longint'($signed(a)) : longint'(a);
    bv = bs ? longint'($signed(b)) : longint'(b);
    return P'(av * bv);
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // One clock: score handshakes at the falling edge, then land 1 time unit after the rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_product", 64'(out_product), 64'(e.p));
          check("sb_tag", 64'(out_tag), 64'(e.t));
        end
        rx_cnt++;
      end
      if (in_valid && in_ready) begin
        e.p = ref_mul(in_a, in_b, in_a_signed, in_b_signed);
        e.t = in_tag;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    in_a        = A_W'($urandom);
    in_b        = B_W'($urandom);
    in_a_signed = 1'($urandom_range(0, 1));
    in_b_signed = 1'($urandom_range(0, 1));
    in_tag      = T_W'($urandom);
  endtask

  // Single transaction into an empty pipe: checks exact latency and result
  task automatic run_one(input string name, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                         input logic as, input logic bs, input logic [T_W-1:0] tag,
                         input logic [P-1:0] expp);
    in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs; in_tag = tag;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    check({name, "_not_early"}, 64'(out_valid), 64'd0);
    step();
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_product"}, 64'(out_product), 64'(expp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    step();
  endtask

  initial begin
    int  base;
    int  n;
    int  vcnt;
    bit  pat [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_a_signed = 1'b0; in_b_signed = 1'b0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_product", 64'(out_product), 64'd0);
    check("reset_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    step();

    // Spec vectors
    run_one("ss_min", A_W'(-1024), B_W'(-128), 1'b1, 1'b1, 4'd3, P'(131072));
    run_one("ss_max", A_W'(1023), B_W'(127), 1'b1, 1'b1, 4'd5, P'(129921));
    run_one("uu_max", A_W'(2047), B_W'(255), 1'b0, 1'b0, 4'd7, P'(521985));
    run_one("su_mix", A_W'(-1024), B_W'(255), 1'b1, 1'b0, 4'd10, P'(-261120));
    run_one("us_mix", A_W'(2047), B_W'(-1), 1'b0, 1'b1, 4'd12, P'(-2047));

    // Streaming: 64 back-to-back random transactions
    base = rx_cnt;
    for (int i = 0; i < 64; i++) begin
      drive_rand();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (9) step();
    check("stream_count", 64'(rx_cnt - base), 64'd64);
    check("stream_idle_after", 64'(out_valid), 64'd0);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure on a full pipe
    base = rx_cnt;
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      in_valid = 1'b1;
      step();
    end
    drive_rand();
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_product_held", 64'(out_product), 64'(exp_q[0].p));
      check("bp_tag_held", 64'(out_tag), 64'(exp_q[0].t));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      step();
      n++;
    end
    check("bp_drain", 64'(exp_q.size()), 64'd0);
    check("bp_count", 64'(rx_cnt - base), 64'd11);

    // Bubbles propagate uncompressed
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    in_a = A_W'(5); in_b = B_W'(7); in_a_signed = 1'b0; in_b_signed = 1'b0; in_tag = 4'd9;
    for (int c = 0; c < 4; c++) begin
      in_valid = pat[c];
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    for (int c = 0; c < 4; c++) begin
      step();
      check("bubble_pattern", 64'(out_valid), 64'(pat[c]));
    end

    // Reset with six transactions in flight
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_product", 64'(out_product), 64'd0);
    check("midrst_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) step();
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) vcnt++;
    end
    check("midrst_no_ghosts", 64'(vcnt), 64'd0);
    run_one("post_rst", A_W'(3), B_W'(5), 1'b0, 1'b0, 4'd6, P'(15));
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
